// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: default geometry, the
// posted-write entry record and the read-response source selector.
package data_mem_responder_pkg;

    localparam int unsigned AW_DEF    = 8;
    localparam int unsigned DW_DEF    = 32;
    localparam int unsigned DEPTH_DEF = 4;

    // One posted write at default widths; wb_fifo stores the same {addr, data}
    // layout at its own parameterised widths.
    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } wb_entry_t;

    // Where the registered read response comes from in the response cycle.
    typedef enum logic {
        SRC_BUF = 1'b0,
        SRC_MEM = 1'b1
    } rd_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Posted-write circular buffer with a youngest-match address lookup.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module wb_fifo
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [AW-1:0] push_addr_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    input  logic [AW-1:0] lookup_addr_i,
    output logic          hit_o,
    output logic [DW-1:0] hit_data_o,
    output logic [AW-1:0] head_addr_o,
    output logic [DW-1:0] head_data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        buf_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign head_addr_o = buf_q[rd_ptr_q].addr;
    assign head_data_o = buf_q[rd_ptr_q].data;

    // Pointer and occupancy next-state; push+pop together keeps the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy registers; reset discards all buffered writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            buf_q[wr_ptr_q] <= '{addr: push_addr_i, data: push_data_i};
        end
    end

    // Scan valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (buf_q[rd_ptr_q + PW'(i)].addr == lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = buf_q[rd_ptr_q + PW'(i)].data;
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Processor data-memory responder: posts writes into wb_fifo, serves reads
// from the buffer or the backing RAM, and arbitrates the single RAM port.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_rd,
    input  logic          req_wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          stall,
    output logic          empty,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    logic          full;
    logic          hit;
    logic [DW-1:0] hit_data;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          push, pop, rd_miss, rd_take;

    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    rd_src_e       src_q, src_d;

    wb_fifo #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk_i         (clk),
        .rst_ni        (rst),
        .push_i        (push),
        .push_addr_i   (addr),
        .push_data_i   (wdata),
        .pop_i         (pop),
        .lookup_addr_i (addr),
        .hit_o         (hit),
        .hit_data_o    (hit_data),
        .head_addr_o   (head_addr),
        .head_data_o   (head_data),
        .full_o        (full),
        .empty_o       (empty)
    );

    // Write acceptance and backing-port arbitration: a missing read owns the
    // port, even when it is dropped in favour of a same-cycle write, so a
    // stream of such requests holds off draining; otherwise the oldest entry
    // drains.
    always_comb begin
        stall     = req_wr && full;
        push      = req_wr && !full;
        rd_take   = req_rd && !req_wr;
        rd_miss   = rst && req_rd && !hit;
        pop       = !empty && !rd_miss;
        mem_re    = rd_miss;
        mem_we    = pop;
        mem_addr  = rd_miss ? addr : head_addr;
        mem_wdata = head_data;
    end

    // Read response next-state: hit data is registered here, miss data is
    // taken from the RAM in the response cycle and then held.
    always_comb begin
        rvalid_d = rd_take;
        src_d    = (rd_take && !hit) ? SRC_MEM : SRC_BUF;
        rdata_d  = rdata_q;
        if (src_q == SRC_MEM) begin
            rdata_d = mem_rdata;
        end
        if (rd_take && hit) begin
            rdata_d = hit_data;
        end
    end

    // Read response registers; reset kills any response in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            src_q    <= SRC_BUF;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            src_q    <= src_d;
        end
    end

    // The RAM output is itself registered one cycle after mem_re, so a miss
    // response passes it straight through rather than adding a cycle.
    assign rdata  = (src_q == SRC_MEM) ? mem_rdata : rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int unsigned AW    = AW_DEF;
    localparam int unsigned DW    = DW_DEF;
    localparam int unsigned DEPTH = DEPTH_DEF;

    logic          clk;
    logic          rst;
    logic          req_rd;
    logic          req_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          stall;
    logic          empty;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;

    int unsigned n_assert;
    int unsigned n_fail;
    wb_entry_t   fill [3];

    data_mem_responder #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .stall     (stall),
        .empty     (empty),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_rd = rd;
        req_wr = wr;
        addr   = a;
        wdata  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        fill[0]   = '{addr: 8'h70, data: 32'h0000_00A0};
        fill[1]   = '{addr: 8'h71, data: 32'h0000_00A1};
        fill[2]   = '{addr: 8'h72, data: 32'h0000_00A2};
        mem_rdata = '0;
        rst       = 1'b0;
        drive(1'b1, 1'b0, 8'h99, '0);
        #2;
        chk("rst_empty",  64'(empty),  64'd1);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata",  64'(rdata),  64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_re", 64'(mem_re), 64'd0);
        chk("rst_stall",  64'(stall),  64'd0);
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0);

        // Single posted write drains once when idle.
        drive(1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF);
        mid();
        chk("w1_stall",  64'(stall),  64'd0);
        chk("w1_empty",  64'(empty),  64'd1);
        chk("w1_mem_we", 64'(mem_we), 64'd0);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        mid();
        chk("w1_drain_empty", 64'(empty),     64'd0);
        chk("w1_drain_we",    64'(mem_we),    64'd1);
        chk("w1_drain_addr",  64'(mem_addr),  64'h10);
        chk("w1_drain_data",  64'(mem_wdata), 64'hDEAD_BEEF);
        tick();
        mid();
        chk("w1_after_we",    64'(mem_we), 64'd0);
        chk("w1_after_empty", 64'(empty),  64'd1);
        tick();

        // Build [0x21=7, 0x20=1], then write 0x20=2 while 0x21 drains, then
        // read 0x20: youngest copy (2) returns while 0x20=1 drains.
        drive(1'b1, 1'b1, 8'h21, 32'h7);
        mid();
        chk("y_a_we", 64'(mem_we), 64'd0);
        tick();
        drive(1'b1, 1'b1, 8'h20, 32'h1);
        mid();
        chk("y_b_we", 64'(mem_we), 64'd0);
        tick();
        drive(1'b0, 1'b1, 8'h20, 32'h2);
        mid();
        chk("y_c_we",   64'(mem_we),    64'd1);
        chk("y_c_addr", 64'(mem_addr),  64'h21);
        chk("y_c_data", 64'(mem_wdata), 64'h7);
        tick();
        drive(1'b1, 1'b0, 8'h20, '0);
        mid();
        chk("y_d_re",   64'(mem_re),    64'd0);
        chk("y_d_we",   64'(mem_we),    64'd1);
        chk("y_d_data", 64'(mem_wdata), 64'h1);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        mid();
        chk("y_e_rvalid", 64'(rvalid),    64'd1);
        chk("y_e_rdata",  64'(rdata),     64'h2);
        chk("y_e_we",     64'(mem_we),    64'd1);
        chk("y_e_data",   64'(mem_wdata), 64'h2);
        tick();
        mid();
        chk("y_f_empty",  64'(empty),  64'd1);
        chk("y_f_rvalid", 64'(rvalid), 64'd0);
        tick();

        // Read miss preempts drain; RAM data returned next cycle and held.
        drive(1'b0, 1'b1, 8'h60, 32'h11);
        tick();
        drive(1'b1, 1'b0, 8'h30, '0);
        mid();
        chk("m_re",   64'(mem_re),   64'd1);
        chk("m_we",   64'(mem_we),   64'd0);
        chk("m_addr", 64'(mem_addr), 64'h30);
        tick();
        mem_rdata = 32'hCAFE_0000;
        drive(1'b0, 1'b0, '0, '0);
        mid();
        chk("m_rvalid",     64'(rvalid),    64'd1);
        chk("m_rdata",      64'(rdata),     64'hCAFE_0000);
        chk("m_drain_we",   64'(mem_we),    64'd1);
        chk("m_drain_addr", 64'(mem_addr),  64'h60);
        chk("m_drain_data", 64'(mem_wdata), 64'h11);
        tick();
        mem_rdata = '0;
        mid();
        chk("m_hold_rvalid", 64'(rvalid), 64'd0);
        chk("m_hold_rdata",  64'(rdata),  64'hCAFE_0000);
        chk("m_hold_empty",  64'(empty),  64'd1);
        tick();

        // Read and write together: write only, no response.
        drive(1'b1, 1'b1, 8'h40, 32'h5);
        mid();
        chk("rw_stall", 64'(stall), 64'd0);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        mid();
        chk("rw_rvalid", 64'(rvalid),    64'd0);
        chk("rw_empty",  64'(empty),     64'd0);
        chk("rw_we",     64'(mem_we),    64'd1);
        chk("rw_addr",   64'(mem_addr),  64'h40);
        chk("rw_data",   64'(mem_wdata), 64'h5);
        tick();
        mid();
        chk("rw_after_empty", 64'(empty), 64'd1);
        tick();

        // Fill to DEPTH with reads missing every cycle, then stall.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 8'(8'h50 + k), 32'(32'h100 + k));
            mid();
            chk("f_stall", 64'(stall),  64'd0);
            chk("f_we",    64'(mem_we), 64'd0);
            tick();
        end
        drive(1'b1, 1'b1, 8'h54, 32'h104);
        mid();
        chk("f5_stall", 64'(stall),  64'd1);
        chk("f5_we",    64'(mem_we), 64'd0);
        chk("f5_re",    64'(mem_re), 64'd1);
        tick();
        drive(1'b0, 1'b1, 8'h54, 32'h104);
        mid();
        chk("f6_stall", 64'(stall),     64'd1);
        chk("f6_we",    64'(mem_we),    64'd1);
        chk("f6_addr",  64'(mem_addr),  64'h50);
        chk("f6_data",  64'(mem_wdata), 64'h100);
        tick();
        mid();
        chk("f7_stall", 64'(stall),    64'd0);
        chk("f7_we",    64'(mem_we),   64'd1);
        chk("f7_addr",  64'(mem_addr), 64'h51);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        for (int k = 2; k < 5; k++) begin
            mid();
            chk("f_drain_we",   64'(mem_we),    64'd1);
            chk("f_drain_addr", 64'(mem_addr),  64'(8'h50 + k));
            chk("f_drain_data", 64'(mem_wdata), 64'(32'h100 + k));
            tick();
        end
        mid();
        chk("f_end_empty", 64'(empty),  64'd1);
        chk("f_end_we",    64'(mem_we), 64'd0);
        tick();

        // Three buffered entries plus a response in flight, then reset.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, fill[k].addr, fill[k].data);
            mid();
            chk("r_fill_we", 64'(mem_we), 64'd0);
            tick();
        end
        drive(1'b1, 1'b0, 8'h99, '0);
        mid();
        chk("r_miss_re", 64'(mem_re), 64'd1);
        chk("r_miss_we", 64'(mem_we), 64'd0);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        #1;
        chk("r_inflight_rvalid", 64'(rvalid), 64'd1);
        chk("r_inflight_empty",  64'(empty),  64'd0);
        rst = 1'b0;
        #1;
        chk("r_async_rvalid", 64'(rvalid), 64'd0);
        chk("r_async_empty",  64'(empty),  64'd1);
        chk("r_async_we",     64'(mem_we), 64'd0);
        chk("r_async_rdata",  64'(rdata),  64'd0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("r_post_we",     64'(mem_we), 64'd0);
            chk("r_post_empty",  64'(empty),  64'd1);
            chk("r_post_rvalid", 64'(rvalid), 64'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
